// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide: one radix-2 step per cycle, result N=XLEN (or WLEN) cycles after accept.
// in_ready only in IDLE; result held in DONE until out_ready; flush aborts from any state.
module mdu_iter #(
  parameter int XLEN = 64,
  parameter int WLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      mdu_op,
  input  logic            mdu_32,
  input  logic [XLEN-1:0] mdu_src1,
  input  logic [XLEN-1:0] mdu_src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] mdu_result
);
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]     cnt;
  logic [7:0]        op;
  logic              w_mode, neg_a, neg_b, div_zero;
  logic [2*XLEN-1:0] opa, acc, opa_nxt, acc_nxt;
  logic [XLEN-1:0]   opb, opb_nxt;

  logic              a_signed, b_signed, a_neg, b_neg, in_mul;
  logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag;
  logic [XLEN:0]     trial, diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem, fin;

  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] x);
    return {{(XLEN-WLEN){x[WLEN-1]}}, x[WLEN-1:0]};
  endfunction

  // Operands are reduced to magnitudes so both iterations run unsigned; signs are reapplied at the end.
  always_comb begin
    a_signed = mdu_op[7] | mdu_op[6] | mdu_op[5] | mdu_op[3] | mdu_op[1];
    b_signed = mdu_op[7] | mdu_op[6] | mdu_op[3] | mdu_op[1];
    in_mul   = |mdu_op[7:4];
    a_ext    = mdu_src1;
    b_ext    = mdu_src2;
    if (mdu_32) begin
      a_ext = {{(XLEN-WLEN){a_signed & mdu_src1[WLEN-1]}}, mdu_src1[WLEN-1:0]};
      b_ext = {{(XLEN-WLEN){b_signed & mdu_src2[WLEN-1]}}, mdu_src2[WLEN-1:0]};
    end
    a_neg = a_signed & a_ext[XLEN-1];
    b_neg = b_signed & b_ext[XLEN-1];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;
  end

  // Divide keeps the dividend MSB-aligned in opb so word mode shifts out the right bits first.
  always_comb begin
    acc_nxt = acc;
    opa_nxt = opa;
    opb_nxt = opb;
    trial   = {acc[XLEN-1:0], opb[XLEN-1]};
    diff    = trial - {1'b0, opa[XLEN-1:0]};
    if (|op[7:4]) begin
      if (opb[0]) acc_nxt = acc + opa;
      opa_nxt = opa << 1;
      opb_nxt = opb >> 1;
    end else begin
      acc_nxt = {{XLEN{1'b0}}, diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0]};
      opb_nxt = {opb[XLEN-2:0], ~diff[XLEN]};
    end
  end

  always_comb begin
    prod = (neg_a ^ neg_b) ? -acc_nxt : acc_nxt;
    quot = div_zero ? '1 : ((neg_a ^ neg_b) ? -opb_nxt : opb_nxt);
    rem  = neg_a ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    fin  = '0;
    if (op[7])           fin = prod[XLEN-1:0];
    else if (|op[6:4])   fin = w_mode ? '0 : prod[2*XLEN-1:XLEN];
    else if (|op[3:2])   fin = quot;
    else if (|op[1:0])   fin = rem;
    if (w_mode) fin = sext_w(fin);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: if (cnt == CW'(1)) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      mdu_result <= '0;
      op         <= '0;
      w_mode     <= 1'b0;
      neg_a      <= 1'b0;
      neg_b      <= 1'b0;
      div_zero   <= 1'b0;
      opa        <= '0;
      opb        <= '0;
      acc        <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (state == IDLE && in_valid) begin
      cnt      <= mdu_32 ? CW'(WLEN) : CW'(XLEN);
      op       <= $onehot(mdu_op) ? mdu_op : 8'h00;
      w_mode   <= mdu_32;
      neg_a    <= a_neg;
      neg_b    <= b_neg;
      div_zero <= (b_ext == '0);
      acc      <= '0;
      opa      <= {{XLEN{1'b0}}, in_mul ? a_mag : b_mag};
      opb      <= in_mul ? b_mag : (mdu_32 ? (a_mag << (XLEN-WLEN)) : a_mag);
    end else if (state == BUSY) begin
      acc <= acc_nxt;
      opa <= opa_nxt;
      opb <= opb_nxt;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) mdu_result <= fin;
    end
  end
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised, multi-cycle multiply/divide unit for RV64M and its W-forms. Sits beside the single-cycle ALU in EX.
- Takes the same one-hot-op / src1 / src2 / 32-bit-mode style of operands as the ALU.
- Adds what the ALU lacks: sequential iteration, a valid/ready handshake on both sides, and flush support.
- EX stalls while an operation is in flight.

Parameters:
- XLEN, 64: datapath width; must be even, at least 8.
- WLEN, 32: word-mode width, applies when mdu_32 is set; WLEN < XLEN.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active low.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request.
- mdu_op  in  8  one-hot {mul, mulh, mulhsu, mulhu, div, divu, rem, remu}, MSB first.
- mdu_32  in  1  W-form: operate on low WLEN bits and sign-extend the result to XLEN.
- mdu_src1  in  XLEN  multiplicand / dividend.
- mdu_src2  in  XLEN  multiplier / divisor.
- flush  in  1  abort any operation in flight.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- mdu_result  out  XLEN  result; held stable while out_valid=1.

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset (rst_n=0 at a clk edge): state=IDLE, in_ready=1, out_valid=0, mdu_result=0, iteration counter=0. Reset overrides every other input, including mid-operation.
- IDLE:
  - in_ready=1.
  - in_valid=1 latches the operands (sign/zero-extended per op, truncated to WLEN if mdu_32), counter=N, and moves to BUSY.
  - N = WLEN if mdu_32, else XLEN.
- BUSY:
  - in_ready=0. One radix-2 step per cycle: shift-add for mul*, restoring subtract for div*/rem*. Counter decrements each cycle.
  - When counter reaches 1, the final value is written into mdu_result and the state moves to DONE.
  - Fixed latency: a request accepted at edge T gives out_valid=1 after edge T+N. That is 64 cycles for XLEN ops and 32 cycles for W ops.
- DONE:
  - out_valid=1, in_ready=0.
  - out_ready=1 returns the unit to IDLE next edge; out_valid drops.
  - No request is accepted in the same cycle as the result handoff.
- Flush:
  - Takes effect in any state: next state=IDLE, out_valid=0, and the result is discarded.
  - A flush asserted together with in_valid in IDLE wins, so the request is not accepted.
  - Reset has priority over flush.
- Result selection:
  - mul: low XLEN bits of the product.
  - mulh: high bits, signed×signed.
  - mulhsu: high bits, signed×unsigned.
  - mulhu: high bits, unsigned×unsigned.
  - Division truncates toward zero. rem takes the sign of the dividend.
- Special cases (fixed latency still applies):
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (most-negative / −1): quotient = dividend; remainder = 0.
- Word mode:
  - mulh/mulhsu/mulhu with mdu_32=1 are illegal and produce result 0.
  - All other word-mode results are computed on WLEN bits, then sign-extended from bit WLEN-1.
  - This covers divuw/remuw too: their WLEN-bit result is sign-extended.
- Illegal mdu_op (zero or more than one bit set): accepted, result 0, same latency.
- Inputs are sampled only at acceptance; changes during BUSY have no effect.

Test Plan:
- Reset then mul, src1=7, src2=−3, mdu_32=0 -> out_valid exactly 64 cycles after acceptance; result 0xFFFF_FFFF_FFFF_FFEB. in_ready=0 throughout BUSY/DONE.
- mulhu 0xFFFF_FFFF_FFFF_FFFF × 2 -> 0x1. mulh −1 × −1 -> 0x0. mulhsu −1 × 2 -> 0xFFFF_FFFF_FFFF_FFFF.
- divw with mdu_32=1, src1=0x0000_0000_8000_0000, src2=0xFFFF_FFFF -> overflow case, result 0xFFFF_FFFF_8000_0000 after 32 cycles. remw on the same operands -> 0.
- div 100/0 -> 0xFFFF_FFFF_FFFF_FFFF. rem 100/0 -> 100. divu −7/2 -> 0x7FFF_FFFF_FFFF_FFFC. rem −7/2 -> 0xFFFF_FFFF_FFFF_FFFF.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid and mdu_result stay stable. Raise out_ready -> IDLE next cycle and in_ready=1.
- Flush at cycle 10 of BUSY -> IDLE next cycle, no out_valid. Next request divu 9/4 -> 2.
- Assert rst_n=0 mid-BUSY -> all outputs return to their reset values next edge.
